// File: rtl/dp64_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dp64_pkg
//  Description : Shared constants for the dp64 SIMD dot-product unit and its
//                accumulating sequencer: precision-mode encoding, controller
//                state encoding and the per-mode dp64 sum widths.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package dp64_pkg;

   // Precision mode encoding carried on cfg_mode
   localparam logic [1:0] MODE_INT16 = 2'd0;
   localparam logic [1:0] MODE_INT8  = 2'd1;
   localparam logic [1:0] MODE_INT4  = 2'd2;
   localparam logic [1:0] MODE_INT2  = 2'd3;

   // Controller state encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // dp64 per-mode sum widths
   localparam int SUM16_W = 35;
   localparam int SUM8_W  = 19;
   localparam int SUM4_W  = 12;
   localparam int SUM2_W  = 11;

endpackage
`default_nettype wire

// File: rtl/dp64.sv
`default_nettype none
// ============================================================================
//  Module      : dp64
//  Description : Combinational SIMD dot product of two 64-bit words. Every
//                lane is treated as unsigned; all four precisions are
//                computed in parallel and the consumer picks one.
//  Ports       : a_i, b_i          - 64-bit operand words
//                sum_int16_o [34:0] - sum of 4  x 16b*16b lane products
//                sum_int8_o  [18:0] - sum of 8  x  8b*8b  lane products
//                sum_int4_o  [11:0] - sum of 16 x  4b*4b  lane products
//                sum_int2_o  [10:0] - sum of 32 x  2b*2b  lane products
//  Revision    : 1.0 - initial release
// ============================================================================
module dp64
   import dp64_pkg::*;
(
   input  logic [63:0]        a_i,
   input  logic [63:0]        b_i,
   output logic [SUM16_W-1:0] sum_int16_o,
   output logic [SUM8_W-1:0]  sum_int8_o,
   output logic [SUM4_W-1:0]  sum_int4_o,
   output logic [SUM2_W-1:0]  sum_int2_o
);

   logic [31:0] w_p16 [4];
   logic [15:0] w_p8  [8];
   logic [7:0]  w_p4  [16];
   logic [3:0]  w_p2  [32];

   // Operands are zero-padded to the full product width so each multiply
   // is exact without relying on context sizing.
   for (genvar i = 0; i < 4; i++) begin : g_lane16
      assign w_p16[i] = {16'b0, a_i[16*i +: 16]} * {16'b0, b_i[16*i +: 16]};
   end

   for (genvar i = 0; i < 8; i++) begin : g_lane8
      assign w_p8[i] = {8'b0, a_i[8*i +: 8]} * {8'b0, b_i[8*i +: 8]};
   end

   for (genvar i = 0; i < 16; i++) begin : g_lane4
      assign w_p4[i] = {4'b0, a_i[4*i +: 4]} * {4'b0, b_i[4*i +: 4]};
   end

   for (genvar i = 0; i < 32; i++) begin : g_lane2
      assign w_p2[i] = {2'b0, a_i[2*i +: 2]} * {2'b0, b_i[2*i +: 2]};
   end

   always_comb begin
      sum_int16_o = '0;
      sum_int8_o  = '0;
      sum_int4_o  = '0;
      sum_int2_o  = '0;
      for (int i = 0; i < 4; i++)  sum_int16_o = sum_int16_o + SUM16_W'(w_p16[i]);
      for (int i = 0; i < 8; i++)  sum_int8_o  = sum_int8_o  + SUM8_W'(w_p8[i]);
      for (int i = 0; i < 16; i++) sum_int4_o  = sum_int4_o  + SUM4_W'(w_p4[i]);
      for (int i = 0; i < 32; i++) sum_int2_o  = sum_int2_o  + SUM2_W'(w_p2[i]);
   end

endmodule
`default_nettype wire

// File: rtl/dp64_accum_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dp64_accum_ctrl
//  Description : Job sequencer and saturating accumulator around dp64.
//                Accepts a (mode, length) descriptor, streams that many
//                operand word pairs through dp64 and returns one scalar sum
//                with a sticky saturation flag per job.
//  Ports       : CLK, nrst            - clock, async active-low reset
//                cfg_valid/ready      - job descriptor handshake
//                cfg_mode, cfg_len    - precision and word count
//                in_valid/ready       - operand pair handshake
//                in_a, in_b           - operand words
//                res_valid/ready      - result handshake
//                res_sum, res_ovf     - accumulated result, saturation flag
//  Revision    : 1.0 - initial release
// ============================================================================
module dp64_accum_ctrl
   import dp64_pkg::*;
#(
   parameter int ACC_W = 48,   // must be >= 35 to hold one int16 word sum
   parameter int LEN_W = 16
)(
   input  logic             CLK,
   input  logic             nrst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [1:0]       cfg_mode,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      in_a,
   input  logic [63:0]      in_b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [ACC_W-1:0] res_sum,
   output logic             res_ovf
);

   logic [1:0]         state_q, state_d;
   logic [1:0]         mode_q;
   logic [LEN_W-1:0]   rem_q;
   logic               s1_valid_q;
   logic [ACC_W-1:0]   s1_val_q, s1_val_d;
   logic               s2_valid_q;
   logic [ACC_W-1:0]   acc_q;
   logic               ovf_q;

   logic               w_cfg_fire;
   logic               w_in_fire;
   logic               w_last_word;
   logic [ACC_W:0]     w_acc_sum;

   logic [SUM16_W-1:0] w_sum16;
   logic [SUM8_W-1:0]  w_sum8;
   logic [SUM4_W-1:0]  w_sum4;
   logic [SUM2_W-1:0]  w_sum2;

   dp64 u_dp64 (
      .a_i         (in_a),
      .b_i         (in_b),
      .sum_int16_o (w_sum16),
      .sum_int8_o  (w_sum8),
      .sum_int4_o  (w_sum4),
      .sum_int2_o  (w_sum2)
   );

   assign w_cfg_fire  = cfg_valid & cfg_ready;
   assign w_in_fire   = in_valid & in_ready;
   assign w_last_word = w_in_fire && (rem_q == LEN_W'(1));

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or negedge nrst) begin
      if (!nrst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (w_cfg_fire) begin
               state_d = (cfg_len == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_last_word) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            // Both stages must have drained so acc holds the final word
            // and the result appears a fixed three edges after the last
            // accept regardless of operand gaps.
            if (!s1_valid_q && !s2_valid_q) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------
   always_comb begin
      cfg_ready = 1'b0;
      in_ready  = 1'b0;
      res_valid = 1'b0;
      case (state_q)
         ST_IDLE:  cfg_ready = 1'b1;
         ST_RUN:   in_ready  = (rem_q != '0);
         ST_DONE:  res_valid = 1'b1;
         default:  ;
      endcase
   end

   // Mode-selected word sum, zero-extended to the accumulator width
   always_comb begin
      s1_val_d = '0;
      case (mode_q)
         MODE_INT16: s1_val_d = ACC_W'(w_sum16);
         MODE_INT8:  s1_val_d = ACC_W'(w_sum8);
         MODE_INT4:  s1_val_d = ACC_W'(w_sum4);
         MODE_INT2:  s1_val_d = ACC_W'(w_sum2);
         default:    s1_val_d = '0;
      endcase
   end

   // One extra bit catches the carry that signals saturation
   assign w_acc_sum = {1'b0, acc_q} + {1'b0, s1_val_q};

   // ---------------------------------------------------------------------
   // Datapath: job bookkeeping, two-stage pipeline, saturating accumulator
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or negedge nrst) begin
      if (!nrst) begin
         mode_q     <= MODE_INT16;
         rem_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_val_q   <= '0;
         s2_valid_q <= 1'b0;
         acc_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         if (w_cfg_fire) begin
            mode_q <= cfg_mode;
            rem_q  <= cfg_len;
         end else if (w_in_fire) begin
            rem_q  <= rem_q - LEN_W'(1);
         end

         s1_valid_q <= w_in_fire;
         if (w_in_fire) begin
            s1_val_q <= s1_val_d;
         end

         s2_valid_q <= s1_valid_q;

         // A new job can only start with the pipeline empty, so the clear
         // never races with an add.
         if (w_cfg_fire) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
         end else if (s1_valid_q) begin
            if (w_acc_sum[ACC_W]) begin
               acc_q <= '1;
               ovf_q <= 1'b1;
            end else begin
               acc_q <= w_acc_sum[ACC_W-1:0];
            end
         end
      end
   end

   assign res_sum = acc_q;
   assign res_ovf = ovf_q;

endmodule
`default_nettype wire
